// File: rtl/sw_poll_pkg.sv
// Shared types and helpers for the switch-poll Avalon-MM read initiator.
// Holds the poll FSM encoding, the PIO data address and counter sizing.
package sw_poll_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_FILTER
   } poll_state_e;

   localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

   // Bits needed to hold a count of 0..n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sw_poll_master_if.sv
// Avalon-MM read-only bus bundle between the poll master and the switch PIO.
interface sw_poll_master_if;

   logic [1:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata
   );

endinterface

// File: rtl/sw_debounce_filter.sv
// Accepts a sampled word once it has been seen DEBOUNCE_N polls in a row and
// reports which bits toggled against the previously accepted value.
module sw_debounce_filter
   import sw_poll_pkg::*;
#(
   parameter int unsigned WIDTH      = 18,
   parameter int unsigned DEBOUNCE_N = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample,
   output logic [WIDTH-1:0] stable,
   output logic             valid,
   output logic             change_pulse,
   output logic [WIDTH-1:0] toggled
);

   localparam int unsigned CNT_W = cnt_width(DEBOUNCE_N + 1);

   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic             valid_q, valid_d;
   logic             pulse_q, pulse_d;
   logic             accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
         valid_q  <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         valid_q  <= valid_d;
         pulse_q  <= pulse_d;
      end
   end

   // toggled is combinational so the parent can merge it on the accepting edge.
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      valid_d  = valid_q;
      pulse_d  = 1'b0;
      toggled  = '0;
      accept   = 1'b0;
      if (sample_valid) begin
         if (sample == cand_q) begin
            if (cnt_q != CNT_W'(DEBOUNCE_N)) cnt_d = cnt_q + 1'b1;
         end else begin
            cand_d = sample;
            cnt_d  = CNT_W'(1);
         end
         accept = (cnt_d == CNT_W'(DEBOUNCE_N)) && (!valid_q || (cand_d != stable_q));
         if (accept) begin
            stable_d = cand_d;
            valid_d  = 1'b1;
            if (valid_q) begin
               pulse_d = 1'b1;
               toggled = cand_d ^ stable_q;
            end
         end
      end
   end

   assign stable       = stable_q;
   assign valid        = valid_q;
   assign change_pulse = pulse_q;

endmodule

// File: rtl/sw_poll_master.sv
// Periodically reads the switch PIO over Avalon-MM, debounces the word and
// keeps a sticky per-bit edge register that raises a level interrupt.
module sw_poll_master
   import sw_poll_pkg::*;
#(
   parameter int unsigned WIDTH        = 18,
   parameter int unsigned POLL_DIV     = 50000,
   parameter int unsigned DEBOUNCE_N   = 4,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   sw_poll_master_if.master     avm,
   output logic [WIDTH-1:0]     sw_stable,
   output logic                 sw_valid,
   output logic                 change_pulse,
   output logic [WIDTH-1:0]     edge_capture,
   input  logic [WIDTH-1:0]     edge_clear,
   output logic                 irq
);

   localparam int unsigned DIV_W = cnt_width(POLL_DIV);
   localparam int unsigned LAT_W = cnt_width(READ_LATENCY);

   poll_state_e      state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] toggled;
   logic             tick;
   logic             sample_valid;
   logic             unused_rd;

   assign unused_rd = ^avm.avm_readdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         lat_q    <= '0;
         sample_q <= '0;
         edge_q   <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         lat_q    <= lat_d;
         sample_q <= sample_d;
         edge_q   <= edge_d;
      end
   end

   assign tick = enable && (div_q == DIV_W'(POLL_DIV - 1));

   always_comb begin
      div_d = div_q + 1'b1;
      if (!enable || tick) div_d = '0;
   end

   // Ticks seen outside IDLE are simply ignored; nothing is queued.
   always_comb begin
      state_d          = state_q;
      lat_d            = lat_q;
      sample_d         = sample_q;
      sample_valid     = 1'b0;
      avm.avm_read     = 1'b0;
      avm.avm_address  = PIO_DATA_ADDR;
      unique case (state_q)
         S_IDLE: begin
            if (tick) state_d = S_REQ;
         end
         S_REQ: begin
            avm.avm_read = 1'b1;
            if (!avm.avm_waitrequest) begin
               state_d = S_WAIT;
               lat_d   = '0;
            end
         end
         S_WAIT: begin
            if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
               sample_d = avm.avm_readdata[WIDTH-1:0];
               state_d  = S_FILTER;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_FILTER: begin
            sample_valid = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   sw_debounce_filter #(
      .WIDTH      (WIDTH),
      .DEBOUNCE_N (DEBOUNCE_N)
   ) u_filter (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .sample       (sample_q),
      .stable       (sw_stable),
      .valid        (sw_valid),
      .change_pulse (change_pulse),
      .toggled      (toggled)
   );

   // A new toggle beats a simultaneous clear of the same bit.
   assign edge_d       = (edge_q & ~edge_clear) | toggled;
   assign edge_capture = edge_q;
   assign irq          = |edge_q;

endmodule

// File: tb/tb_sw_poll_master.sv
// Directed bench for sw_poll_master with a 1-latency switch PIO model
// that supports programmable waitrequest stalls.
module tb_sw_poll_master;

   localparam int unsigned W = 18;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         enable = 1'b0;
   logic [W-1:0] edge_clear = '0;
   logic [W-1:0] sw_stable;
   logic         sw_valid;
   logic         change_pulse;
   logic [W-1:0] edge_capture;
   logic         irq;

   logic [W-1:0] sw_in = '0;
   int           stall_cfg = 0;
   int           stall_left = 0;
   int           cyc = 0;
   int           pulse_count = 0;
   int           addr_err = 0;
   int           read_cycles = 0;
   int           total = 0;
   int           bad = 0;

   sw_poll_master_if avm_if ();

   sw_poll_master #(
      .WIDTH        (18),
      .POLL_DIV     (8),
      .DEBOUNCE_N   (3),
      .READ_LATENCY (1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .avm          (avm_if),
      .sw_stable    (sw_stable),
      .sw_valid     (sw_valid),
      .change_pulse (change_pulse),
      .edge_capture (edge_capture),
      .edge_clear   (edge_clear),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   // PIO model: stalls stall_cfg cycles per read, data valid one cycle after accept.
   assign avm_if.avm_waitrequest = avm_if.avm_read && (stall_left != 0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!avm_if.avm_read) stall_left <= stall_cfg;
      else if (stall_left != 0) stall_left <= stall_left - 1;
      if (avm_if.avm_read && !avm_if.avm_waitrequest) avm_if.avm_readdata <= {14'h2A5A, sw_in};
      else avm_if.avm_readdata <= '1;
   end

   always @(negedge clk) begin
      if (avm_if.avm_read === 1'b1) begin
         read_cycles <= read_cycles + 1;
         if (avm_if.avm_address !== 2'd0) addr_err <= addr_err + 1;
      end
      if (change_pulse === 1'b1) pulse_count <= pulse_count + 1;
   end

   // Runs one poll: returns posedge index of the read start and the read-high length.
   task automatic do_poll(input logic [W-1:0] val, input bit drop_en,
                          output int start, output int hi);
      int n;
      sw_in = val;
      start = -1;
      hi    = 0;
      n     = 0;
      while (avm_if.avm_read !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (avm_if.avm_read !== 1'b1) begin
         bad++;
         $display("FAIL poll_timeout: avm_read=%b required 1 within 40 cycles", avm_if.avm_read);
         return;
      end
      start = cyc;
      if (drop_en) enable = 1'b0;
      while (avm_if.avm_read === 1'b1 && hi < 40) begin
         hi++;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      logic exp_rd;
      enable = 1'b1;
      sw_in  = 18'h00055;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({avm_if.avm_read, avm_if.avm_address, sw_valid, change_pulse, irq} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl: read/addr/valid/pulse/irq=%b required 00000",
                  {avm_if.avm_read, avm_if.avm_address, sw_valid, change_pulse, irq});
      end
      total++;
      if ({sw_stable, edge_capture} !== '0) begin
         bad++;
         $display("FAIL reset_data: stable=%h edge=%h required 0/0", sw_stable, edge_capture);
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         exp_rd = (k == 8 || k == 16);
         total++;
         if (avm_if.avm_read !== exp_rd) begin
            bad++;
            $display("FAIL read_schedule cycle %0d: avm_read=%b required %b", k, avm_if.avm_read, exp_rd);
         end
      end
   endtask

   task automatic test_startup();
      int s, h;
      repeat (2) @(negedge clk);
      total++;
      if (sw_valid !== 1'b0) begin
         bad++;
         $display("FAIL startup_after2: sw_valid=%b required 0", sw_valid);
      end
      do_poll(18'h00055, 1'b0, s, h);
      total++;
      if ({sw_valid, change_pulse, irq} !== 3'b100 || sw_stable !== 18'h00055) begin
         bad++;
         $display("FAIL startup_accept: valid/pulse/irq=%b stable=%h required 100 00055",
                  {sw_valid, change_pulse, irq}, sw_stable);
      end
      total++;
      if (edge_capture !== '0 || pulse_count !== 0) begin
         bad++;
         $display("FAIL startup_edges: edge=%h pulses=%0d required 0 0", edge_capture, pulse_count);
      end
   endtask

   task automatic test_bounce();
      logic [W-1:0] seq [8];
      int s, h, pc0;
      seq = '{18'h00054, 18'h00055, 18'h00054, 18'h00055, 18'h00054, 18'h00055,
              18'h00054, 18'h00054};
      pc0 = pulse_count;
      for (int i = 0; i < 8; i++) begin
         do_poll(seq[i], 1'b0, s, h);
         total++;
         if (sw_stable !== 18'h00055) begin
            bad++;
            $display("FAIL bounce_hold poll %0d: stable=%h required 00055", i, sw_stable);
         end
      end
      do_poll(18'h00054, 1'b0, s, h);
      total++;
      if (sw_stable !== 18'h00054 || change_pulse !== 1'b1) begin
         bad++;
         $display("FAIL bounce_accept: stable=%h pulse=%b required 00054 1", sw_stable, change_pulse);
      end
      total++;
      if (edge_capture !== 18'h00001 || irq !== 1'b1) begin
         bad++;
         $display("FAIL bounce_edge: edge=%h irq=%b required 00001 1", edge_capture, irq);
      end
      @(negedge clk);
      total++;
      if (change_pulse !== 1'b0 || pulse_count - pc0 !== 1) begin
         bad++;
         $display("FAIL bounce_pulse_once: pulse=%b count=%0d required 0 1", change_pulse, pulse_count - pc0);
      end
   endtask

   task automatic test_clear_vs_set();
      int s, h;
      edge_clear = 18'h00001;
      @(negedge clk);
      total++;
      if (edge_capture !== '0 || irq !== 1'b0) begin
         bad++;
         $display("FAIL clear: edge=%h irq=%b required 0 0", edge_capture, irq);
      end
      for (int i = 0; i < 3; i++) do_poll(18'h00055, 1'b0, s, h);
      total++;
      if (edge_capture !== 18'h00001 || sw_stable !== 18'h00055 || change_pulse !== 1'b1) begin
         bad++;
         $display("FAIL set_wins: edge=%h stable=%h pulse=%b required 00001 00055 1",
                  edge_capture, sw_stable, change_pulse);
      end
      @(negedge clk);
      total++;
      if (edge_capture !== '0) begin
         bad++;
         $display("FAIL clear_after_set: edge=%h required 0", edge_capture);
      end
      edge_clear = '0;
   endtask

   task automatic test_waitrequest();
      int s1, s2, h;
      stall_cfg = 3;
      for (int i = 0; i < 3; i++) begin
         do_poll(18'h2AAAA, 1'b0, s1, h);
         total++;
         if (h !== 4) begin
            bad++;
            $display("FAIL stall_read_len poll %0d: read cycles=%0d required 4", i, h);
         end
      end
      total++;
      if (sw_stable !== 18'h2AAAA || edge_capture !== 18'h2AAFF || irq !== 1'b1) begin
         bad++;
         $display("FAIL stall_data: stable=%h edge=%h irq=%b required 2aaaa 2aaff 1",
                  sw_stable, edge_capture, irq);
      end
      edge_clear = '1;
      @(negedge clk);
      edge_clear = '0;
      stall_cfg = 10;
      do_poll(18'h2AAAA, 1'b0, s1, h);
      total++;
      if (h !== 11) begin
         bad++;
         $display("FAIL long_stall_len: read cycles=%0d required 11", h);
      end
      stall_cfg = 0;
      do_poll(18'h2AAAA, 1'b0, s2, h);
      total++;
      if (s2 - s1 !== 16) begin
         bad++;
         $display("FAIL tick_dropped: read spacing=%0d required 16", s2 - s1);
      end
   endtask

   task automatic test_enable_drop();
      int s, h, rc0;
      stall_cfg = 2;
      do_poll(18'h000F0, 1'b0, s, h);
      do_poll(18'h000F0, 1'b0, s, h);
      do_poll(18'h000F0, 1'b1, s, h);
      total++;
      if (h !== 3 || sw_stable !== 18'h000F0 || change_pulse !== 1'b1) begin
         bad++;
         $display("FAIL enable_drop_complete: len=%0d stable=%h pulse=%b required 3 000f0 1",
                  h, sw_stable, change_pulse);
      end
      total++;
      if (edge_capture !== 18'h2AA5A) begin
         bad++;
         $display("FAIL enable_drop_edge: edge=%h required 2aa5a", edge_capture);
      end
      rc0 = read_cycles;
      repeat (30) @(negedge clk);
      total++;
      if (read_cycles - rc0 !== 0) begin
         bad++;
         $display("FAIL enable_drop_idle: read cycles=%0d required 0", read_cycles - rc0);
      end
      stall_cfg = 0;
   endtask

   task automatic test_reset_mid();
      int n, c0;
      enable = 1'b1;
      n = 0;
      while (avm_if.avm_read !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({avm_if.avm_read, sw_valid, irq} !== 3'b000 || sw_stable !== '0 || edge_capture !== '0) begin
         bad++;
         $display("FAIL reset_in_wait: read/valid/irq=%b stable=%h edge=%h required 000 0 0",
                  {avm_if.avm_read, sw_valid, irq}, sw_stable, edge_capture);
      end
      @(negedge clk);
      reset_n = 1'b1;
      c0 = cyc;
      n = 0;
      while (avm_if.avm_read !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (avm_if.avm_read !== 1'b1 || cyc - c0 !== 8) begin
         bad++;
         $display("FAIL reset_restart: read=%b after %0d cycles required 1 after 8",
                  avm_if.avm_read, cyc - c0);
      end
      stall_cfg = 5;
      repeat (10) @(negedge clk);
      n = 0;
      while (avm_if.avm_read !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (avm_if.avm_read !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_req: avm_read=%b required 0", avm_if.avm_read);
      end
      @(negedge clk);
      reset_n = 1'b1;
      stall_cfg = 0;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_bounce();
      test_clear_vs_set();
      test_waitrequest();
      test_enable_drop();
      test_reset_mid();
      total++;
      if (addr_err !== 0) begin
         bad++;
         $display("FAIL address_zero: bad address cycles=%0d required 0", addr_err);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
